// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: DC->MEM register, load response wait/hold, load extension.
// Optional stall-cycle counter port enabled by defining MEM_STALL_CNT_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [77:0] dc_to_mem_bus,
    input  logic [31:0] data_sram_rdata,
    input  logic        data_ok,
    output logic [69:0] mem_to_wb_bus,
    output logic [37:0] mem_to_rf_bus,
    output logic        stallreq_for_mem
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [31:0] mem_stall_cycles
`endif
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t      r_state;
    logic [77:0] r_bus;
    logic [31:0] r_rdata_buf;

    logic [31:0] w_ex_result;
    logic [4:0]  w_rf_waddr;
    logic        w_rf_we;
    logic [2:0]  w_load_op;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic [31:0] w_pc;
    logic        w_is_load;
    logic        w_bubble;
    logic        w_rewrite;
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;
    logic        w_stall_unused;

    assign w_ex_result = r_bus[31:0];
    assign w_rf_waddr  = r_bus[36:32];
    assign w_rf_we     = r_bus[37];
    assign w_load_op   = r_bus[40:38];
    assign w_ram_en    = r_bus[41];
    assign w_ram_wen   = r_bus[45:42];
    assign w_pc        = r_bus[77:46];

    assign w_is_load      = w_ram_en & (w_ram_wen == 4'd0);
    assign w_bubble       = stall[4] & ~stall[5];
    assign w_rewrite      = ~stall[4] | ~stall[5];
    assign w_stall_unused = ^stall[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus <= 78'd0;
        end else if (w_bubble) begin
            r_bus <= 78'd0;
        end else if (!stall[4]) begin
            r_bus <= dc_to_mem_bus;
        end
    end

    // A response arriving while this stage is frozen must be parked, since the
    // memory will not repeat it once the stall lifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rdata_buf <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_load && data_ok && stall[4]) begin
                        r_state     <= S_HOLD;
                        r_rdata_buf <= data_sram_rdata;
                    end
                end
                S_HOLD: begin
                    if (w_rewrite) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stallreq_for_mem = w_is_load & (r_state != S_HOLD) & ~data_ok;

    assign w_raw  = (r_state == S_HOLD) ? r_rdata_buf : data_sram_rdata;
    assign w_half = w_ex_result[1] ? w_raw[31:16] : w_raw[15:0];

    always_comb begin
        w_byte = w_raw[7:0];
        case (w_ex_result[1:0])
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            2'd3:    w_byte = w_raw[31:24];
            default: w_byte = w_raw[7:0];
        endcase
    end

    always_comb begin
        w_load_data = w_raw;
        case (w_load_op)
            3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load_data = {24'd0, w_byte};
            3'd2:    w_load_data = {{16{w_half[15]}}, w_half};
            3'd3:    w_load_data = {16'd0, w_half};
            default: w_load_data = w_raw;
        endcase
    end

    assign w_rf_wdata    = w_is_load ? w_load_data : w_ex_result;
    assign mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_to_rf_bus = {w_rf_we, w_rf_waddr, w_rf_wdata};

`ifdef MEM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (stallreq_for_mem) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign mem_stall_cycles = r_stall_cnt;
`endif

endmodule
